// File: rtl/rr_stage_arbiter.sv
// Round-robin arbiter feeding one registered output stage with valid/ready.
// Optional ARB_BURST_EN lets a winner hold priority for up to BURST grants.
module rr_stage_arbiter #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int SRC_W = (N > 1) ? $clog2(N) : 1,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   din,
    output logic [N-1:0]     grant,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SRC_W-1:0] out_src,
    input  logic             out_ready
);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("rr_stage_arbiter: N must be 2..16");
    end
    if (BURST < 1) begin : g_bad_burst
        $error("rr_stage_arbiter: BURST must be >= 1");
    end

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [SRC_W-1:0] out_src_q, out_src_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;

    logic             load;
    logic             any_req;
    logic [SRC_W-1:0] win;
    logic [N-1:0]     gnt;
    logic [W-1:0]     win_data;

    function automatic logic [SRC_W-1:0] inc(input logic [SRC_W-1:0] x);
        return (x == SRC_W'(N - 1)) ? '0 : x + 1'b1;
    endfunction

    // Stage accepts a word when empty or draining this cycle.
    assign load = ~out_valid_q | out_ready;

    // Rotating priority scan starting at ptr.
    always_comb begin
        int unsigned idx;
        win     = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                win     = SRC_W'(idx);
            end
        end
    end

    assign win_data = din[int'(win)*W +: W];

    // One-hot grant, suppressed in reset and under backpressure.
    always_comb begin
        gnt = '0;
        if (!reset && load && any_req) begin
            gnt[win] = 1'b1;
        end
    end

    assign grant = gnt;

`ifdef ARB_BURST_EN
    localparam int CNT_W = $clog2(BURST + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d, nxt_cnt;
    logic [SRC_W-1:0] last_q, last_d;
`endif

    // Next state of the output register and priority pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
`ifdef ARB_BURST_EN
        cnt_d       = cnt_q;
        last_d      = last_q;
        nxt_cnt     = '0;
`endif
        if (load) begin
            if (any_req) begin
                out_valid_d = 1'b1;
                out_data_d  = win_data;
                out_src_d   = win;
`ifdef ARB_BURST_EN
                // Consecutive grants to one winner keep ptr on it.
                if (win == last_q && cnt_q != '0) begin
                    nxt_cnt = cnt_q + 1'b1;
                end else begin
                    nxt_cnt = CNT_W'(1);
                end
                last_d = win;
                if (nxt_cnt >= CNT_W'(BURST)) begin
                    ptr_d = inc(win);
                    cnt_d = '0;
                end else begin
                    ptr_d = win;
                    cnt_d = nxt_cnt;
                end
`else
                ptr_d = inc(win);
`endif
            end else begin
                out_valid_d = 1'b0;
`ifdef ARB_BURST_EN
                if (cnt_q != '0 && !req[last_q]) begin
                    ptr_d = inc(last_q);
                    cnt_d = '0;
                end
`endif
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

`ifdef ARB_BURST_EN
    // Burst tracking registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: doc/rr_stage_arbiter.md
Name: rr_stage_arbiter

Overview:
Round-robin arbiter that shares one registered pipeline stage between N requesters. Each requester offers a W-bit word. One winner per cycle is latched into the output register, together with its source index. Downstream consumes the output through a valid/ready handshake. The block sits in front of single-cycle delay/register stages wherever several producers feed one datapath.

Parameters:
W, 8, data width per requester
N, 4, number of requesters (2..16)
SRC_W, $clog2(N) (minimum 1), width of source index
BURST, 4, maximum consecutive grants to one requester (used only with ARB_BURST_EN)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  N  request per requester; bit i = requester i
din  input  N*W  flattened data; requester i occupies bits [i*W +: W]
grant  output  N  combinational one-hot; bit i high = requester i's word is taken this cycle
out_valid  output  1  output register holds a word
out_data  output  W  latched word
out_src  output  SRC_W  index of the requester that supplied out_data
out_ready  input  1  downstream accepts out_data when out_valid && out_ready

Behaviour:
- Reset, sampled on clk while reset=1:
  - out_valid=0, out_data=0, out_src=0, priority pointer ptr=0, burst counter=0.
  - grant=0 whenever reset=1.
- load = ~out_valid | out_ready. The stage can take a new word when it is empty or being drained in the same cycle. No bubble on back-to-back traffic.
- Arbitration, combinational, only when load=1:
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, ... N-1, 0, ... ptr-1.
  - grant = onehot(winner). grant=0 if load=0 or req=0.
- On each clock edge with a grant:
  - out_data <= din[winner], out_src <= winner, out_valid <= 1.
  - ptr <= (winner+1) mod N; wrap from N-1 to 0.
- load=1 with no req: out_valid <= 0. If out_valid was 1, the held word is dropped because it was consumed. out_data and out_src hold their old values.
- load=0 (out_valid=1, out_ready=0): out_data, out_src, out_valid and ptr all hold. grant=0.
- Latency: request granted in cycle t appears with out_valid=1 in cycle t+1.
- Requester contract:
  - A requester keeps req high and din stable until its grant bit is seen high.
  - Deasserting req before grant withdraws the request with no side effects.
- Fairness: with all req held high and out_ready=1, grants rotate 0,1,...,N-1,0. No requester waits more than N-1 grants.
- Reset mid-operation: the pending output word is discarded and the pointer returns to 0 on the next edge. No grant is issued in the reset cycle.
- out_ready is ignored when out_valid=0.

Optional Feature:
ARB_BURST_EN
- Defined:
  - The winner keeps top priority (ptr not advanced) for up to BURST consecutive grants while its req stays high.
  - A burst counter counts consecutive grants to the same winner. When it reaches BURST, or the winner's req drops, ptr <= winner+1 and the counter is cleared.
  - A grant to a different requester restarts the counter at 1.
- Undefined: no burst counter exists. ptr advances on every grant, exactly as described in Behaviour. BURST is unused.

Test Plan:
- Reset: assert reset 2 cycles with req=4'b1111 -> grant=0 throughout. After release: out_valid=0, out_data=0, out_src=0.
- Rotation: N=4, W=8, req=4'b1111, din={8'h44,8'h33,8'h22,8'h11}, out_ready=1 -> out_src sequence 0,1,2,3,0 with out_data 11,22,33,44,11. out_valid stays 1 from the second cycle on.
- Backpressure: out_valid=1 holding 8'h22 (src 1), out_ready=0 for 3 cycles with req=4'b1111 -> grant=0 and out_data stays 8'h22. Raise out_ready -> grant=4'b0100 the same cycle, and out_data=8'h33 on the next cycle.
- Wrap and skip: ptr=3, req=4'b0010 -> grant=4'b0010, out_src=1 next cycle, ptr becomes 2. Then req=0, out_ready=1 -> out_valid falls to 0 one cycle later.
- Reset mid-operation: out_valid=1, out_ready=0, ptr=2; pulse reset 1 cycle -> out_valid=0 next cycle. With req=4'b1111 afterwards, the first grant is 4'b0001.
- ARB_BURST_EN, BURST=2: req=4'b0011 held, out_ready=1 -> out_src sequence 0,0,1,1,0,0. Without the macro the same stimulus gives 0,1,0,1.
